// File: rtl/control_unit.sv
// RV32I main decoder: maps opcode/funct3/funct7 to the ID/EXE control bundle.
// Purely combinational; illegal encodings decode to the all-zero (flush) bundle.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [1:0] result_src,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic       mem_store,
  output logic       mem_load,
  output logic [3:0] alu_control,
  output logic       alu_src,
  output logic [2:0] imm_src,
  output logic       register_write
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluSll   = 4'b0010;
  localparam logic [3:0] AluSlt   = 4'b0011;
  localparam logic [3:0] AluSltu  = 4'b0100;
  localparam logic [3:0] AluXor   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluOr    = 4'b1000;
  localparam logic [3:0] AluAnd   = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;
  localparam logic [3:0] AluAuipc = 4'b1011;

  localparam logic [2:0] ImmI     = 3'b000;
  localparam logic [2:0] ImmS     = 3'b001;
  localparam logic [2:0] ImmB     = 3'b010;
  localparam logic [2:0] ImmJ     = 3'b011;
  localparam logic [2:0] ImmShamt = 3'b100;
  localparam logic [2:0] ImmU     = 3'b101;

  // Clock and reset exist only for interface uniformity with the other decode blocks.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  logic       f7_zero;
  logic       f7_alt;
  logic       is_shift;
  logic [3:0] alu_base;
  logic [3:0] alu_alt;

  assign f7_zero  = (funct7 == 7'h00);
  assign f7_alt   = (funct7 == 7'h20);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // funct3 map without funct7 modifier, and with it (only ADD/SRL have alternates).
  always_comb begin
    alu_base = AluAdd;
    unique case (funct3)
      3'b000: alu_base = AluAdd;
      3'b001: alu_base = AluSll;
      3'b010: alu_base = AluSlt;
      3'b011: alu_base = AluSltu;
      3'b100: alu_base = AluXor;
      3'b101: alu_base = AluSrl;
      3'b110: alu_base = AluOr;
      3'b111: alu_base = AluAnd;
      default: alu_base = AluAdd;
    endcase
    alu_alt = alu_base;
    if (funct3 == 3'b000) alu_alt = AluSub;
    if (funct3 == 3'b101) alu_alt = AluSra;
  end

  always_comb begin
    result_src     = 2'b00;
    branch         = 1'b0;
    jal            = 1'b0;
    jalr           = 1'b0;
    mem_store      = 1'b0;
    mem_load       = 1'b0;
    alu_control    = AluAdd;
    alu_src        = 1'b0;
    imm_src        = ImmI;
    register_write = 1'b0;
    case (op)
      OpLoad: begin
        mem_load       = 1'b1;
        register_write = 1'b1;
        alu_src        = 1'b1;
        result_src     = 2'b01;
      end
      OpStore: begin
        mem_store = 1'b1;
        alu_src   = 1'b1;
        imm_src   = ImmS;
      end
      OpImm: begin
        // Shift immediates reuse funct7 as an opcode extension; other funct3 carry imm bits.
        if (funct3 == 3'b001 && f7_zero) begin
          register_write = 1'b1;
          alu_src        = 1'b1;
          imm_src        = ImmShamt;
          alu_control    = alu_base;
        end else if (funct3 == 3'b101 && (f7_zero || f7_alt)) begin
          register_write = 1'b1;
          alu_src        = 1'b1;
          imm_src        = ImmShamt;
          alu_control    = f7_alt ? alu_alt : alu_base;
        end else if (!is_shift) begin
          register_write = 1'b1;
          alu_src        = 1'b1;
          alu_control    = alu_base;
        end
      end
      OpReg: begin
        if (f7_zero) begin
          register_write = 1'b1;
          alu_control    = alu_base;
        end else if (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          register_write = 1'b1;
          alu_control    = alu_alt;
        end
      end
      OpBranch: begin
        branch      = 1'b1;
        imm_src     = ImmB;
        alu_control = AluSub;
      end
      OpJal: begin
        jal            = 1'b1;
        register_write = 1'b1;
        result_src     = 2'b10;
        imm_src        = ImmJ;
      end
      OpJalr: begin
        jalr           = 1'b1;
        register_write = 1'b1;
        result_src     = 2'b10;
        alu_src        = 1'b1;
      end
      OpLui: begin
        register_write = 1'b1;
        alu_src        = 1'b1;
        imm_src        = ImmU;
        alu_control    = AluPassB;
      end
      OpAuipc: begin
        register_write = 1'b1;
        alu_src        = 1'b1;
        imm_src        = ImmU;
        alu_control    = AluAuipc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed opcode cases plus a broad op/funct3/funct7 sweep,
// scoreboarded against an independent reference model; invariants checked on every output.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] result_src;
  logic       branch, jal, jalr, mem_store, mem_load, alu_src, register_write;
  logic [3:0] alu_control;
  logic [2:0] imm_src;

  int checks_q;
  int failures_q;

  typedef struct {
    string      tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  bit       drive_done;

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .result_src     (result_src),
    .branch         (branch),
    .jal            (jal),
    .jalr           (jalr),
    .mem_store      (mem_store),
    .mem_load       (mem_load),
    .alu_control    (alu_control),
    .alu_src        (alu_src),
    .imm_src        (imm_src),
    .register_write (register_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      failures_q++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Field order: result_src, branch, jal, jalr, mem_store, mem_load, alu, alu_src, imm, rw.
  function automatic logic [15:0] pack(input logic [1:0] rs, input logic br, input logic j,
                                       input logic jr, input logic st, input logic ld,
                                       input logic [3:0] alu, input logic as,
                                       input logic [2:0] is, input logic rw);
    return {rs, br, j, jr, st, ld, alu, as, is, rw};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic logic [15:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic alt;
    alt = (f7 == 7'h20);
    case (o)
      7'h03: return pack(2'b01, 0, 0, 0, 0, 1, 4'd0, 1, 3'd0, 1);
      7'h23: return pack(2'b00, 0, 0, 0, 1, 0, 4'd0, 1, 3'd1, 0);
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? pack(0, 0, 0, 0, 0, 0, 4'd2, 1, 3'd4, 1) : '0;
        if (f3 == 3'd5)
          return (f7 == 7'h00 || alt) ? pack(0, 0, 0, 0, 0, 0, ref_alu(f3, alt), 1, 3'd4, 1)
                                      : '0;
        return pack(0, 0, 0, 0, 0, 0, ref_alu(f3, 1'b0), 1, 3'd0, 1);
      end
      7'h33: begin
        if (f7 == 7'h00) return pack(0, 0, 0, 0, 0, 0, ref_alu(f3, 1'b0), 0, 3'd0, 1);
        if (alt && (f3 == 3'd0 || f3 == 3'd5))
          return pack(0, 0, 0, 0, 0, 0, ref_alu(f3, 1'b1), 0, 3'd0, 1);
        return '0;
      end
      7'h63: return pack(2'b00, 1, 0, 0, 0, 0, 4'd1, 0, 3'd2, 0);
      7'h6F: return pack(2'b10, 0, 1, 0, 0, 0, 4'd0, 0, 3'd3, 1);
      7'h67: return pack(2'b10, 0, 0, 1, 0, 0, 4'd0, 1, 3'd0, 1);
      7'h37: return pack(2'b00, 0, 0, 0, 0, 0, 4'd10, 1, 3'd5, 1);
      7'h17: return pack(2'b00, 0, 0, 0, 0, 0, 4'd11, 1, 3'd5, 1);
      default: return '0;
    endcase
  endfunction

  task automatic drive(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [15:0] exp);
    sb_item_t it;
    @(posedge clk);
    op     = o;
    funct3 = f3;
    funct7 = f7;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin
    logic [15:0] obs;
    sb_item_t    it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        obs = {result_src, branch, jal, jalr, mem_store, mem_load, alu_control, alu_src,
               imm_src, register_write};
        check_eq(it.tag, {16'd0, obs}, {16'd0, it.exp});
        check_eq({it.tag, "_onehot"},
                 {31'd0, $countones({branch, jal, jalr, mem_load, mem_store}) <= 1}, 32'd1);
        check_eq({it.tag, "_norw"}, {31'd0, (mem_store | branch) & register_write}, 32'd0);
        check_eq({it.tag, "_ldsrc"}, {31'd0, (result_src == 2'b01) == mem_load}, 32'd1);
      end
    end
  end

  initial begin
    logic [6:0] f7_set [4];
    checks_q   = 0;
    failures_q = 0;
    drive_done = 1'b0;
    rst    = 1'b1;
    op     = 7'h00;
    funct3 = 3'd0;
    funct7 = 7'h00;

    // Reset does not gate the decode: op=0 is illegal, so all zero.
    drive("reset_zero", 7'h00, 3'd0, 7'h00, 16'h0000);
    drive("reset_lui", 7'h37, 3'd0, 7'h00, pack(0, 0, 0, 0, 0, 0, 4'd10, 1, 3'd5, 1));
    @(posedge clk);
    rst = 1'b0;

    drive("add", 7'h33, 3'd0, 7'h00, pack(0, 0, 0, 0, 0, 0, 4'd0, 0, 3'd0, 1));
    drive("sub", 7'h33, 3'd0, 7'h20, pack(0, 0, 0, 0, 0, 0, 4'd1, 0, 3'd0, 1));
    drive("sra_r", 7'h33, 3'd5, 7'h20, pack(0, 0, 0, 0, 0, 0, 4'd7, 0, 3'd0, 1));
    drive("and_alt_ill", 7'h33, 3'd7, 7'h20, 16'h0000);
    drive("mul_ill", 7'h33, 3'd0, 7'h01, 16'h0000);
    drive("srai", 7'h13, 3'd5, 7'h20, pack(0, 0, 0, 0, 0, 0, 4'd7, 1, 3'd4, 1));
    drive("srli", 7'h13, 3'd5, 7'h00, pack(0, 0, 0, 0, 0, 0, 4'd6, 1, 3'd4, 1));
    drive("slli_ill", 7'h13, 3'd1, 7'h20, 16'h0000);
    drive("addi_neg", 7'h13, 3'd0, 7'h7F, pack(0, 0, 0, 0, 0, 0, 4'd0, 1, 3'd0, 1));
    drive("ori", 7'h13, 3'd6, 7'h20, pack(0, 0, 0, 0, 0, 0, 4'd8, 1, 3'd0, 1));
    drive("load", 7'h03, 3'd2, 7'h00, pack(2'b01, 0, 0, 0, 0, 1, 4'd0, 1, 3'd0, 1));
    drive("store", 7'h23, 3'd2, 7'h00, pack(0, 0, 0, 0, 1, 0, 4'd0, 1, 3'd1, 0));
    drive("beq", 7'h63, 3'd0, 7'h00, pack(0, 1, 0, 0, 0, 0, 4'd1, 0, 3'd2, 0));
    drive("bgeu", 7'h63, 3'd7, 7'h3F, pack(0, 1, 0, 0, 0, 0, 4'd1, 0, 3'd2, 0));
    drive("jal", 7'h6F, 3'd0, 7'h00, pack(2'b10, 0, 1, 0, 0, 0, 4'd0, 0, 3'd3, 1));
    drive("jalr", 7'h67, 3'd0, 7'h00, pack(2'b10, 0, 0, 1, 0, 0, 4'd0, 1, 3'd0, 1));
    drive("lui", 7'h37, 3'd3, 7'h11, pack(0, 0, 0, 0, 0, 0, 4'd10, 1, 3'd5, 1));
    drive("auipc", 7'h17, 3'd0, 7'h00, pack(0, 0, 0, 0, 0, 0, 4'd11, 1, 3'd5, 1));
    drive("fence", 7'h0F, 3'd0, 7'h00, 16'h0000);
    drive("ecall", 7'h73, 3'd0, 7'h00, 16'h0000);

    // Sweep every opcode and funct3 against the interesting funct7 values plus a random one.
    for (int o = 0; o < 128; o++) begin
      f7_set = '{7'h00, 7'h20, 7'h01, 7'($urandom_range(127))};
      for (int f = 0; f < 8; f++) begin
        for (int k = 0; k < 4; k++) begin
          drive($sformatf("sweep_op%02h_f3%0d_f7%02h", o, f, f7_set[k]), 7'(o), 3'(f),
                f7_set[k], model(7'(o), 3'(f), f7_set[k]));
        end
      end
    end
    drive_done = 1'b1;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) check_eq("sb_drain_timeout", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule
